mem_req_ctrl: RTL and testbench
===============================

MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: number of WAIT cycles without mem_done before a timeout error. Used only when MEM_REQ_TIMEOUT_EN is defined.
REQ-002 Ports: clk  in  1  single clock; all state updates on the rising edge.
REQ-003 Ports: rst  in  1  synchronous, active-high reset.
REQ-004 Ports: req_rd, req_wr  in  1 each  pipeline read / write request.
REQ-005 Ports: req_addr, req_wdata  in  16 each  request byte address / store data.
REQ-006 Ports: pipe_stall  out  1  holds the pipeline; resp_valid  out  1  one-cycle completion pulse.
REQ-007 Ports: resp_rdata  out  16  load data, registered; err  out  1  one-cycle error pulse.
REQ-008 Ports: mem_addr, mem_datain  out  16 each; mem_rd, mem_wr  out  1 each. These drive the mem_system request inputs.
REQ-009 Ports: mem_dataout  in  16; mem_done, mem_cachehit, mem_err  in  1 each. These come from the mem_system outputs.
REQ-010 Ports: hit_cnt, acc_cnt  out  16 each  saturating hit / access counters.

Function
REQ-011 The FSM has states IDLE, WAIT, RESP, ERR and a 2-bit state register.
REQ-012 IDLE, valid request (req_rd XOR req_wr, req_addr[0]=0):
- latch addr, wdata and the op;
- pipe_stall=1 combinationally in this cycle;
- next state WAIT.
REQ-013 IDLE, illegal request (req_rd & req_wr, or (req_rd|req_wr) & req_addr[0]=1): nothing is latched; next state ERR.
REQ-014 IDLE with no request: pipe_stall=0 and the state remains IDLE.
REQ-015 WAIT outputs:
- mem_addr and mem_datain carry the latched values;
- mem_rd or mem_wr is held high per the latched op;
- pipe_stall=1.
REQ-016 WAIT transitions:
- mem_err=1 → ERR; mem_err takes priority over a simultaneous mem_done;
- else mem_done=1 on a read → capture mem_dataout into resp_rdata, then RESP;
- else mem_done=1 on a write → RESP with resp_rdata unchanged.
REQ-017 In WAIT, mem_rd and mem_wr deassert in the cycle after mem_done or mem_err is sampled. They are never high in IDLE, RESP or ERR.
REQ-018 RESP: resp_valid=1 and pipe_stall=0 for exactly one cycle; request inputs are ignored; next state IDLE.
REQ-019 ERR: err=1 and pipe_stall=0 for exactly one cycle; resp_valid=0; next state IDLE.
REQ-020 Latency: accept at cycle T and mem_done at T+k (k≥1) give resp_valid at T+k+1.
REQ-021 Request inputs presented in WAIT are ignored; the latched values are used throughout.
REQ-022 acc_cnt increments by 1 on every entry to RESP and saturates at 16'hFFFF (no wrap).
REQ-023 hit_cnt increments by 1 when mem_done & mem_cachehit is sampled in WAIT without mem_err, and saturates at 16'hFFFF.

Reset
REQ-024 On rst the following are cleared at the next edge:
- state = IDLE;
- resp_rdata, hit_cnt, acc_cnt, latched addr/wdata/op, and the timeout counter (when present) = 0.
REQ-025 During rst, all outputs are 0, including mem_rd, mem_wr and pipe_stall.
REQ-026 Reset asserted in WAIT aborts the transaction: mem_rd/mem_wr drop in the cycle after rst is sampled, and no resp_valid or err pulse follows.

Configuration
REQ-027 Macro MEM_REQ_TIMEOUT_EN, when defined:
- a counter, cleared on entry to WAIT, increments each WAIT cycle;
- reaching TIMEOUT_CYCLES without mem_done forces ERR and deasserts mem_rd/mem_wr.
REQ-028 Macro MEM_REQ_TIMEOUT_EN, when undefined: the timeout counter is not built, and WAIT waits indefinitely for mem_done or mem_err.

Verification
REQ-029 Read hit: req_rd=1, req_addr=16'h0010, mem_done+mem_cachehit 1 cycle after accept, mem_dataout=16'hBEEF → resp_valid 2 cycles after accept, resp_rdata=16'hBEEF, hit_cnt=1, acc_cnt=1.
REQ-030 Write miss: req_wr=1, req_addr=16'h0A02, req_wdata=16'h1234, mem_done 12 cycles after accept → mem_wr=1, mem_addr=16'h0A02 and mem_datain=16'h1234 for 12 cycles, resp_valid at cycle 13, hit_cnt unchanged.
REQ-031 Misaligned: req_rd=1, req_addr=16'h0005 → err=1 one cycle later, mem_rd never asserted. Both req_rd and req_wr set with req_addr=16'h0004 → same result.
REQ-032 mem_done and mem_err in the same WAIT cycle → err pulse, no resp_valid, acc_cnt unchanged.
REQ-033 rst asserted 3 cycles into WAIT → mem_rd=0 at the next cycle, all counters 0, no resp_valid.
REQ-034 MEM_REQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, mem_done held 0 → err after 8 WAIT cycles. Same stimulus with the macro undefined → stall persists for 100 cycles with no err.

Source files
------------

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: pipeline-to-mem_system request FSM with saturating hit/access counters; WAIT timeout under MEM_REQ_TIMEOUT_EN.
// Latency: resp_valid one cycle after mem_done is sampled; pipe_stall holds the pipeline from accept until RESP/ERR.
module mem_req_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        pipe_stall,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_datain,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_dataout,
    input  logic        mem_done,
    input  logic        mem_cachehit,
    input  logic        mem_err,
    output logic [15:0] hit_cnt,
    output logic [15:0] acc_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        op_wr_q, op_wr_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] acc_cnt_q, acc_cnt_d;

`ifdef MEM_REQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
`endif

    logic req_any, req_ok;
    logic stall_c, rd_c, wr_c, resp_c, err_c;

    assign req_any = req_rd | req_wr;
    assign req_ok  = (req_rd ^ req_wr) & ~req_addr[0];

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        op_wr_d   = op_wr_q;
        rdata_d   = rdata_q;
        hit_cnt_d = hit_cnt_q;
        acc_cnt_d = acc_cnt_q;
`ifdef MEM_REQ_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
`endif
        stall_c   = 1'b0;
        rd_c      = 1'b0;
        wr_c      = 1'b0;
        resp_c    = 1'b0;
        err_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Any request holds the pipeline until its RESP or ERR pulse.
                if (req_any) begin
                    stall_c = 1'b1;
                    if (req_ok) begin
                        addr_d  = req_addr;
                        wdata_d = req_wdata;
                        op_wr_d = req_wr;
                        state_d = S_WAIT;
`ifdef MEM_REQ_TIMEOUT_EN
                        to_cnt_d = '0;
`endif
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_WAIT: begin
                stall_c = 1'b1;
                rd_c    = ~op_wr_q;
                wr_c    = op_wr_q;
                if (mem_err) begin
                    state_d = S_ERR;
                end else if (mem_done) begin
                    if (!op_wr_q) begin
                        rdata_d = mem_dataout;
                    end
                    if (mem_cachehit && hit_cnt_q != 16'hFFFF) begin
                        hit_cnt_d = hit_cnt_q + 16'd1;
                    end
                    if (acc_cnt_q != 16'hFFFF) begin
                        acc_cnt_d = acc_cnt_q + 16'd1;
                    end
                    state_d = S_RESP;
`ifdef MEM_REQ_TIMEOUT_EN
                end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_ERR;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
`endif
                end
            end
            S_RESP: begin
                resp_c  = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                err_c   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            op_wr_q   <= 1'b0;
            rdata_q   <= '0;
            hit_cnt_q <= '0;
            acc_cnt_q <= '0;
`ifdef MEM_REQ_TIMEOUT_EN
            to_cnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            op_wr_q   <= op_wr_d;
            rdata_q   <= rdata_d;
            hit_cnt_q <= hit_cnt_d;
            acc_cnt_q <= acc_cnt_d;
`ifdef MEM_REQ_TIMEOUT_EN
            to_cnt_q  <= to_cnt_d;
`endif
        end
    end

    // Outputs are forced low while rst is high, before the first reset edge lands.
    assign pipe_stall = ~rst & stall_c;
    assign resp_valid = ~rst & resp_c;
    assign err        = ~rst & err_c;
    assign mem_rd     = ~rst & rd_c;
    assign mem_wr     = ~rst & wr_c;
    assign mem_addr   = (~rst && state_q == S_WAIT) ? addr_q  : 16'h0000;
    assign mem_datain = (~rst && state_q == S_WAIT) ? wdata_q : 16'h0000;
    assign resp_rdata = rst ? 16'h0000 : rdata_q;
    assign hit_cnt    = rst ? 16'h0000 : hit_cnt_q;
    assign acc_cnt    = rst ? 16'h0000 : acc_cnt_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl: read hit, write miss, illegal requests, done+err, reset abort, timeout / no-timeout.
module tb_mem_req_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_rd, req_wr;
    logic [15:0] req_addr, req_wdata;
    logic        pipe_stall, resp_valid, err;
    logic [15:0] resp_rdata;
    logic [15:0] mem_addr, mem_datain;
    logic        mem_rd, mem_wr;
    logic [15:0] mem_dataout;
    logic        mem_done, mem_cachehit, mem_err;
    logic [15:0] hit_cnt, acc_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_req_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_rd       (req_rd),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .pipe_stall   (pipe_stall),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .err          (err),
        .mem_addr     (mem_addr),
        .mem_datain   (mem_datain),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_dataout  (mem_dataout),
        .mem_done     (mem_done),
        .mem_cachehit (mem_cachehit),
        .mem_err      (mem_err),
        .hit_cnt      (hit_cnt),
        .acc_cnt      (acc_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clr_req();
        req_rd    = 1'b0;
        req_wr    = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 16'h0000;
    endtask

    initial begin
        int cnt;
        int bad;

        rst = 1'b1;
        clr_req();
        mem_dataout  = 16'h0000;
        mem_done     = 1'b0;
        mem_cachehit = 1'b0;
        mem_err      = 1'b0;
        tick();
        tick();

        // Outputs during reset, even with a request pending
        req_rd = 1'b1;
        #1;
        chk("rst_stall", {31'd0, pipe_stall}, 32'd0);
        chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("rst_resp_err", {30'd0, resp_valid, err}, 32'd0);
        chk("rst_cnts", {hit_cnt, acc_cnt}, 32'd0);
        clr_req();
        rst = 1'b0;
        tick();

        // Idle with no request
        #1;
        chk("idle_stall", {31'd0, pipe_stall}, 32'd0);

        // Read hit at 0x0010, done one cycle after accept
        req_rd = 1'b1; req_addr = 16'h0010;
        #1;
        chk("rd_accept_stall", {31'd0, pipe_stall}, 32'd1);
        tick();
        clr_req();
        mem_done = 1'b1; mem_cachehit = 1'b1; mem_dataout = 16'hBEEF;
        #1;
        chk("rd_wait_memrd", {15'd0, mem_rd, mem_addr}, {15'd0, 1'b1, 16'h0010});
        chk("rd_wait_stall", {31'd0, pipe_stall}, 32'd1);
        tick();
        mem_done = 1'b0; mem_cachehit = 1'b0; mem_dataout = 16'h0000;
        #1;
        chk("rd_resp_valid", {30'd0, resp_valid, pipe_stall}, {30'd0, 2'b10});
        chk("rd_resp_rdata", {16'd0, resp_rdata}, {16'd0, 16'hBEEF});
        chk("rd_cnts", {hit_cnt, acc_cnt}, {16'd1, 16'd1});
        chk("rd_resp_memrd", {31'd0, mem_rd}, 32'd0);
        tick();
        #1;
        chk("rd_resp_onecycle", {31'd0, resp_valid}, 32'd0);

        // Write miss at 0x0A02, done 12 cycles after accept; request inputs wiggle in WAIT
        req_wr = 1'b1; req_addr = 16'h0A02; req_wdata = 16'h1234;
        tick();
        clr_req();
        cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            if (i == 2) begin
                req_rd = 1'b1; req_addr = 16'hFFFF; req_wdata = 16'h5555;
            end
            if (i == 12) clr_req();
            mem_done = (i == 12);
            #1;
            if (mem_wr && !mem_rd && mem_addr == 16'h0A02 && mem_datain == 16'h1234 && pipe_stall)
                cnt++;
            tick();
        end
        mem_done = 1'b0;
        #1;
        chk("wr_wait_cycles", cnt, 32'd12);
        chk("wr_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("wr_memwr_drop", {31'd0, mem_wr}, 32'd0);
        chk("wr_cnts", {hit_cnt, acc_cnt}, {16'd1, 16'd2});
        chk("wr_rdata_kept", {16'd0, resp_rdata}, {16'd0, 16'hBEEF});
        tick();

        // Misaligned read
        req_rd = 1'b1; req_addr = 16'h0005;
        #1;
        chk("mis_accept_memrd", {31'd0, mem_rd}, 32'd0);
        tick();
        clr_req();
        #1;
        chk("mis_err", {29'd0, err, resp_valid, mem_rd}, {29'd0, 3'b100});
        tick();
        #1;
        chk("mis_err_onecycle", {31'd0, err}, 32'd0);

        // Read and write together
        req_rd = 1'b1; req_wr = 1'b1; req_addr = 16'h0004;
        tick();
        clr_req();
        #1;
        chk("both_err", {28'd0, err, resp_valid, mem_rd, mem_wr}, {28'd0, 4'b1000});
        tick();

        // mem_done and mem_err together: error wins
        req_rd = 1'b1; req_addr = 16'h0020;
        tick();
        clr_req();
        mem_done = 1'b1; mem_err = 1'b1; mem_cachehit = 1'b1;
        tick();
        mem_done = 1'b0; mem_err = 1'b0; mem_cachehit = 1'b0;
        #1;
        chk("dnerr_err", {30'd0, err, resp_valid}, {30'd0, 2'b10});
        chk("dnerr_cnts", {hit_cnt, acc_cnt}, {16'd1, 16'd2});
        tick();

        // Timeout behaviour with mem_done held low
        req_rd = 1'b1; req_addr = 16'h0030;
        tick();
        clr_req();
`ifdef MEM_REQ_TIMEOUT_EN
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (mem_rd && pipe_stall && !err) cnt++;
            tick();
        end
        #1;
        chk("to_wait_cycles", cnt, 32'd8);
        chk("to_err", {29'd0, err, mem_rd, resp_valid}, {29'd0, 3'b100});
        tick();
`else
        cnt = 0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (mem_rd && pipe_stall) cnt++;
            if (err || resp_valid) bad++;
            tick();
        end
        chk("nto_stall_cycles", cnt, 32'd100);
        chk("nto_no_err", bad, 32'd0);
        mem_err = 1'b1;
        tick();
        mem_err = 1'b0;
        #1;
        chk("nto_exit_err", {31'd0, err}, 32'd1);
        tick();
`endif

        // Reset three cycles into WAIT aborts the read
        req_rd = 1'b1; req_addr = 16'h0040;
        tick();
        clr_req();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("abort_rst_memrd", {30'd0, mem_rd, pipe_stall}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("abort_memrd", {30'd0, mem_rd, pipe_stall}, 32'd0);
        chk("abort_cnts", {hit_cnt, acc_cnt}, 32'd0);
        chk("abort_rdata", {16'd0, resp_rdata}, 32'd0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            if (resp_valid || err || mem_rd) bad++;
        end
        chk("abort_no_pulse", bad, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
